// File: rtl/rs_pkg.sv
// rs_pkg: field, code and generator constants plus FSM states for the RS(204,188) encoder.
//   GF_POLY  primitive polynomial x^8+x^4+x^3+x^2+1
//   N, K     codeword and message length in bytes; NPAR parity bytes
//   G[j]     coefficient of x^j in g(x) = prod_{i=0..15}(x + alpha^i); the x^16 term is implicit
package rs_pkg;
    localparam logic [8:0] GF_POLY = 9'h11D;
    localparam int N    = 204;
    localparam int K    = 188;
    localparam int NPAR = 16;
    localparam logic [7:0] G [NPAR] = '{
        8'h3B, 8'h24, 8'h32, 8'h62, 8'hE5, 8'h29, 8'h41, 8'hA3,
        8'h08, 8'h1E, 8'hD1, 8'h44, 8'hBD, 8'h68, 8'h0D, 8'h3B
    };
    typedef enum logic {DATA, PARITY} state_t;
endpackage

// File: rtl/rs_gf_mul_const.sv
// rs_gf_mul_const: combinational GF(2^8) multiply by a constant, reduced by GF_POLY.
//   C    param 8  constant factor (tuple form)
//   a_i  in    8  multiplicand (tuple form)
//   p_o  out   8  a_i * C
module rs_gf_mul_const
    import rs_pkg::*;
#(
    parameter logic [7:0] C = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);
    logic [7:0] acc;
    logic [7:0] sh;
    // sh walks a_i * x^b (reduced each step); acc sums the terms selected by the bits of C
    always_comb begin
        acc = '0;
        sh  = a_i;
        for (int b = 0; b < 8; b++) begin
            acc = C[b] ? acc ^ sh : acc;
            sh  = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
        end
        p_o = acc;
    end
endmodule

// File: rtl/rs_encoder_204_188.sv
// rs_encoder_204_188: streaming systematic RS(204,188,t=8) encoder, 188 message bytes then 16 parity bytes.
//   Clk        in   1  clock, rising edge
//   Reset      in   1  asynchronous active-low reset
//   in_valid   in   1  in_data valid
//   in_data    in   8  message byte
//   in_ready   out  1  byte accepted when in_valid && in_ready
//   out_valid  out  1  out_data holds a codeword byte
//   out_data   out  8  codeword byte (message first, then parity highest coefficient first)
//   out_sop    out  1  codeword byte 0
//   out_eop    out  1  codeword byte 203
//   out_ready  in   1  downstream takes out_data when out_valid && out_ready
module rs_encoder_204_188
    import rs_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sop,
    output logic       out_eop,
    input  logic       out_ready
);
    state_t               state_q;
    logic [7:0]           cnt_q;
    logic [NPAR-1:0][7:0] p_q;
    logic [NPAR-1:0][7:0] p_d;
    logic [NPAR-1:0][7:0] fbg;
    logic [7:0]           fb;
    logic                 slot_free;
    logic                 accept;
    logic                 emit;
    logic                 last_msg;
    logic                 last_par;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state_q == DATA) && slot_free;
    assign accept    = in_valid && in_ready;
    assign emit      = (state_q == PARITY) && slot_free;
    assign last_msg  = cnt_q == 8'(K - 1);
    assign last_par  = cnt_q == 8'(N - K - 1);
    assign fb        = in_data ^ p_q[NPAR-1];

    for (genvar j = 0; j < NPAR; j++) begin : g_mul
        rs_gf_mul_const #(.C(G[j])) u_mul (.a_i(fb), .p_o(fbg[j]));
    end

    // message byte: one division step by g(x); parity slot: shift toward p[15], zero enters p[0]
    // so the register is clean again when the next packet starts
    assign p_d = accept ? {p_q[NPAR-2:0], 8'h00} ^ fbg
               : emit   ? {p_q[NPAR-2:0], 8'h00}
               : p_q;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= DATA;
            cnt_q     <= '0;
            p_q       <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            p_q <= p_d;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
                out_sop   <= cnt_q == '0;
                out_eop   <= 1'b0;
                cnt_q     <= last_msg ? '0 : cnt_q + 8'd1;
                state_q   <= last_msg ? PARITY : DATA;
            end else if (emit) begin
                out_valid <= 1'b1;
                out_data  <= p_q[NPAR-1];
                out_sop   <= 1'b0;
                out_eop   <= last_par;
                cnt_q     <= last_par ? '0 : cnt_q + 8'd1;
                state_q   <= last_par ? DATA : PARITY;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs_encoder_204_188.sv
// tb_rs_encoder_204_188: self-checking bench for the RS(204,188) encoder against a division-based reference model.
module tb_rs_encoder_204_188;
    typedef logic [7:0] bq_t[$];

    logic       Clk;
    logic       Reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] gen [17];
    logic [7:0] alpha [16];
    bq_t        out_q;
    bq_t        ref_q;
    bq_t        rand_stream;
    logic       sop_q [$];
    logic       eop_q [$];
    int         cyc_q [$];
    int         ncyc = 0;
    int         low_cnt = 0;
    int         stall_viol = 0;
    logic       stall_prev = 1'b0;
    logic [9:0] prev = '0;

    rs_encoder_204_188 dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_ready(out_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        ncyc++;
        if (Reset && out_valid && out_ready) begin
            out_q.push_back(out_data);
            sop_q.push_back(out_sop);
            eop_q.push_back(out_eop);
            cyc_q.push_back(ncyc);
        end
        if (Reset && !in_ready) low_cnt++;
        if (Reset && stall_prev && {out_data, out_sop, out_eop} !== prev) stall_viol++;
        stall_prev = Reset && out_valid && !out_ready;
        prev = {out_data, out_sop, out_eop};
    end

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1D : 8'h00);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic void init_model();
        alpha[0] = 8'h01;
        for (int i = 1; i < 16; i++) alpha[i] = gf_mul(alpha[i-1], 8'h02);
        for (int k = 0; k < 17; k++) gen[k] = 8'h00;
        gen[0] = 8'h01;
        for (int i = 0; i < 16; i++)
            for (int k = 16; k >= 0; k--)
                gen[k] = gf_mul(gen[k], alpha[i]) ^ (k > 0 ? gen[k-1] : 8'h00);
    endfunction

    function automatic bq_t encode(input bq_t m);
        logic [7:0] w [204];
        logic [7:0] f;
        bq_t        cw;
        for (int i = 0; i < 204; i++) w[i] = (i < 188) ? m[i] : 8'h00;
        for (int c = 0; c < 188; c++) begin
            f = w[c];
            for (int k = 0; k < 17; k++) w[c+k] = w[c+k] ^ gf_mul(f, gen[16-k]);
        end
        cw = m;
        for (int i = 188; i < 204; i++) cw.push_back(w[i]);
        return cw;
    endfunction

    function automatic int syn_bad(input bq_t cw);
        int         n = 0;
        logic [7:0] s;
        for (int i = 0; i < 16; i++) begin
            s = 8'h00;
            foreach (cw[c]) s = gf_mul(s, alpha[i]) ^ cw[c];
            if (s != 8'h00) n++;
        end
        return n;
    endfunction

    function automatic void clear_mon();
        out_q.delete();
        sop_q.delete();
        eop_q.delete();
        cyc_q.delete();
        low_cnt = 0;
        stall_viol = 0;
    endfunction

    task automatic drive(input bq_t msg, input int gap, input int stall, input int n_out);
        int idx = 0;
        int cyc = 0;
        while ((idx < msg.size() || out_q.size() < n_out) && cyc < 60000) begin
            @(posedge Clk); #1;
            in_valid  = (idx < msg.size()) && ($urandom_range(99) >= gap);
            in_data   = (idx < msg.size()) ? msg[idx] : 8'h00;
            out_ready = $urandom_range(99) >= stall;
            @(negedge Clk);
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        @(posedge Clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        checks++; if (out_sop !== 1'b0) begin errors++; $display("FAIL reset_out_sop: got %b want 0", out_sop); end
        checks++; if (out_eop !== 1'b0) begin errors++; $display("FAIL reset_out_eop: got %b want 0", out_eop); end
        @(negedge Clk); Reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_all_zero();
        bq_t m;
        int  nz = 0;
        int  fr = 0;
        clear_mon();
        repeat (188) m.push_back(8'h00);
        drive(m, 0, 0, 204);
        checks++; if (out_q.size() != 204) begin errors++; $display("FAIL zero_len: got %0d want 204", out_q.size()); end
        for (int k = 0; k < 204; k++) begin
            if (out_q[k] !== 8'h00) nz++;
            if (sop_q[k] !== (k == 0) || eop_q[k] !== (k == 203)) fr++;
        end
        checks++; if (nz != 0) begin errors++; $display("FAIL zero_data: got %0d nonzero bytes want 0", nz); end
        checks++; if (fr != 0) begin errors++; $display("FAIL zero_framing: got %0d bad sop/eop want 0", fr); end
        checks++; if (low_cnt != 16) begin errors++; $display("FAIL zero_in_ready_low: got %0d cycles want 16", low_cnt); end
    endtask

    task automatic test_impulse();
        bq_t m;
        int  bad = 0;
        clear_mon();
        repeat (187) m.push_back(8'h00);
        m.push_back(8'h01);
        drive(m, 0, 0, 204);
        checks++; if (out_q.size() != 204) begin errors++; $display("FAIL imp_len: got %0d want 204", out_q.size()); end
        for (int k = 0; k < 188; k++) if (out_q[k] !== m[k]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL imp_msg: got %0d bad bytes want 0", bad); end
        for (int k = 188; k < 204; k++) begin
            checks++;
            if (out_q[k] !== gen[203-k]) begin
                errors++; $display("FAIL imp_par%0d: got %h want %h", k, out_q[k], gen[203-k]);
            end
        end
    endtask

    task automatic test_random();
        bq_t m;
        bq_t got;
        bq_t exp;
        int  bad;
        clear_mon();
        rand_stream.delete();
        for (int p = 0; p < 188; p++)
            for (int i = 0; i < 188; i++)
                rand_stream.push_back(i == 0 ? ((p % 8 == 0) ? 8'hB8 : 8'h47)
                                    : (i % 47 == 0) ? 8'h47 : 8'($urandom_range(255)));
        drive(rand_stream, 0, 0, 188 * 204);
        checks++; if (out_q.size() != 188 * 204) begin errors++; $display("FAIL rand_len: got %0d want %0d", out_q.size(), 188 * 204); end
        for (int p = 0; p < 188; p++) begin
            m.delete();
            got.delete();
            for (int i = 0; i < 188; i++) m.push_back(rand_stream[p*188+i]);
            for (int i = 0; i < 204; i++) got.push_back(out_q[p*204+i]);
            exp = encode(m);
            bad = 0;
            for (int i = 0; i < 204; i++) if (got[i] !== exp[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_cw pkt %0d: got %0d bad bytes want 0", p, bad); end
            bad = syn_bad(got);
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_syn pkt %0d: got %0d nonzero syndromes want 0", p, bad); end
            bad = 0;
            for (int i = 0; i < 204; i++) if (sop_q[p*204+i] !== (i == 0) || eop_q[p*204+i] !== (i == 203)) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL rand_framing pkt %0d: got %0d bad flags want 0", p, bad); end
        end
        ref_q.delete();
        for (int i = 0; i < 6 * 204; i++) ref_q.push_back(out_q[i]);
    endtask

    task automatic test_backpressure();
        bq_t m;
        int  bad = 0;
        clear_mon();
        for (int i = 0; i < 6 * 188; i++) m.push_back(rand_stream[i]);
        drive(m, 30, 40, 6 * 204);
        checks++; if (out_q.size() != 6 * 204) begin errors++; $display("FAIL bp_len: got %0d want %0d", out_q.size(), 6 * 204); end
        for (int i = 0; i < 6 * 204; i++) if (out_q[i] !== ref_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_data: got %0d bytes differing from no-stall run want 0", bad); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stall_viol); end
    endtask

    task automatic test_reset_mid();
        bq_t m;
        bq_t exp;
        int  bad = 0;
        for (int i = 0; i < 101; i++) begin
            @(posedge Clk); #1;
            in_valid  = 1'b1;
            in_data   = (i == 100) ? 8'hA5 : 8'($urandom_range(255));
            out_ready = 1'b1;
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin errors++; $display("FAIL mid_pre: got %b/%h want 1/a5", out_valid, out_data); end
        #2 Reset = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL mid_out_data: got %h want 00", out_data); end
        checks++; if (out_sop !== 1'b0 || out_eop !== 1'b0) begin errors++; $display("FAIL mid_flags: got %b%b want 00", out_sop, out_eop); end
        @(negedge Clk); Reset = 1'b1;
        clear_mon();
        m.push_back(8'h47);
        repeat (187) m.push_back(8'($urandom_range(255)));
        exp = encode(m);
        drive(m, 0, 0, 204);
        checks++; if (out_q.size() != 204) begin errors++; $display("FAIL mid_len: got %0d want 204", out_q.size()); end
        for (int i = 0; i < 204; i++) if (out_q[i] !== exp[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_cw: got %0d bad bytes want 0", bad); end
        checks++; if (sop_q[0] !== 1'b1 || eop_q[203] !== 1'b1) begin errors++; $display("FAIL mid_framing: got sop %b eop %b want 1 1", sop_q[0], eop_q[203]); end
    endtask

    task automatic test_back_to_back();
        bq_t m;
        bq_t got;
        bq_t exp;
        int  gaps = 0;
        int  fr = 0;
        int  bad;
        clear_mon();
        for (int i = 0; i < 3 * 188; i++) m.push_back((i % 188 == 0) ? 8'h47 : 8'($urandom_range(255)));
        drive(m, 0, 0, 612);
        checks++; if (out_q.size() != 612) begin errors++; $display("FAIL b2b_len: got %0d want 612", out_q.size()); end
        for (int k = 0; k < 612; k++) begin
            if (cyc_q[k] - cyc_q[0] != k) gaps++;
            if (eop_q[k] !== (k == 203 || k == 407 || k == 611) || sop_q[k] !== (k % 204 == 0)) fr++;
        end
        checks++; if (gaps != 0) begin errors++; $display("FAIL b2b_gaps: got %0d late bytes want 0", gaps); end
        checks++; if (fr != 0) begin errors++; $display("FAIL b2b_framing: got %0d bad flags want 0", fr); end
        for (int p = 0; p < 3; p++) begin
            got.delete();
            exp.delete();
            for (int i = 0; i < 188; i++) exp.push_back(m[p*188+i]);
            exp = encode(exp);
            for (int i = 0; i < 204; i++) got.push_back(out_q[p*204+i]);
            bad = 0;
            for (int i = 0; i < 204; i++) if (got[i] !== exp[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL b2b_cw pkt %0d: got %0d bad bytes want 0", p, bad); end
        end
    endtask

    initial begin
        init_model();
        Reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        test_reset();
        test_all_zero();
        test_impulse();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
